// File: rtl/muldiv_sequencer_if.sv
// Handshake/bus bundle for the iterative RV32M multiply/divide sequencer.
// master = execute-stage issuer, slave = muldiv_sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [5:0]      ALUControl;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] resultMulDiv;
    logic            zero;

    modport master (
        output start, ALUControl, operand1, operand2, flush,
        input  busy, done, resultMulDiv, zero
    );

    modport slave (
        input  start, ALUControl, operand1, operand2, flush,
        output busy, done, resultMulDiv, zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 RV32M sequencer: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once multiplier bits run out.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              fast_q;
    logic [XLEN-1:0]   fres_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvsr_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   res_q;
    logic              zero_q;

    logic [2:0]        op_d;
    logic              neg1_d;
    logic              neg2_d;
    logic [XLEN-1:0]   mag1_d;
    logic [XLEN-1:0]   mag2_d;
    logic              neg_d;
    logic              div0_d;
    logic              ovf_d;
    logic [XLEN-1:0]   fres_d;
    logic              accept_d;

    logic [2*XLEN-1:0] prod_d;
    logic [XLEN:0]     rsh_d;
    logic [XLEN:0]     diff_d;
    logic              take_d;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;

    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f;
    logic [XLEN-1:0]   rem_f;
    logic [XLEN-1:0]   res_d;
    logic              last_d;

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.resultMulDiv = res_q;
    assign bus.zero         = zero_q;

    // Accept-time decode: operand signedness, magnitudes, result sign, fast paths
    always_comb begin
        op_d     = bus.ALUControl[2:0];
        accept_d = bus.start && !bus.flush && (bus.ALUControl[5:3] == 3'b011);
        neg1_d   = 1'b0;
        neg2_d   = 1'b0;
        unique case (op_d)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                neg1_d = bus.operand1[XLEN-1];
                neg2_d = bus.operand2[XLEN-1];
            end
            3'b010: neg1_d = bus.operand1[XLEN-1];
            default: ;
        endcase
        mag1_d = neg1_d ? (~bus.operand1 + 1'b1) : bus.operand1;
        mag2_d = neg2_d ? (~bus.operand2 + 1'b1) : bus.operand2;
        neg_d  = op_d[2] && op_d[1] ? neg1_d : (neg1_d ^ neg2_d);
        div0_d = op_d[2] && (bus.operand2 == '0);
        ovf_d  = op_d[2] && !op_d[0]
               && (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.operand2 == '1);
        fres_d = '0;
        if (div0_d) begin
            fres_d = op_d[1] ? bus.operand1 : '1;
        end else if (ovf_d) begin
            fres_d = op_d[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One radix-2 step of each datapath plus the sign fix-up and result select
    always_comb begin
        prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
        rsh_d  = {rem_q, quo_q[XLEN-1]};
        diff_d = rsh_d - {1'b0, dvsr_q};
        take_d = !diff_d[XLEN];
        rem_d  = take_d ? diff_d[XLEN-1:0] : rsh_d[XLEN-1:0];
        quo_d  = {quo_q[XLEN-2:0], take_d};
        last_d = (cnt_q == CW'(1));
        prod_f = neg_q ? (~prod_q + 1'b1) : prod_q;
        quo_f  = neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_f  = neg_q ? (~rem_q + 1'b1) : rem_q;
        res_d  = '0;
        if (fast_q) begin
            res_d = fres_q;
        end else begin
            unique case (op_q)
                3'b000:                 res_d = prod_f[XLEN-1:0];
                3'b001, 3'b010, 3'b011: res_d = prod_f[2*XLEN-1:XLEN];
                3'b100, 3'b101:         res_d = quo_f;
                default:                res_d = rem_f;
            endcase
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic early_d;

    // Multiply may stop once no multiplier bits remain after this step
    always_comb begin
        early_d = !op_q[2] && ((mplier_q >> 1) == '0);
    end
`endif

    // Sequencer FSM with registered busy/done/result/zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            fres_q   <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        state_q  <= CALC;
                        op_q     <= op_d;
                        neg_q    <= neg_d;
                        fast_q   <= div0_d | ovf_d;
                        fres_q   <= fres_d;
                        cnt_q    <= CW'(XLEN);
                        prod_q   <= '0;
                        mcand_q  <= {{XLEN{1'b0}}, mag1_d};
                        mplier_q <= mag2_d;
                        rem_q    <= '0;
                        quo_q    <= mag1_d;
                        dvsr_q   <= mag2_d;
                        busy_q   <= 1'b1;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (fast_q) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (op_q[2]) begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                        end else begin
                            prod_q   <= prod_d;
                            mcand_q  <= mcand_q << 1;
                            mplier_q <= mplier_q >> 1;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (last_d || early_d) begin
                            state_q <= FIX;
                        end
`else
                        if (last_d) begin
                            state_q <= FIX;
                        end
`endif
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DONE;
                        res_q   <= res_d;
                        zero_q  <= (res_d == '0);
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;
    localparam int FAST = 2;

    localparam logic [5:0] OP_MUL    = 6'b011000;
    localparam logic [5:0] OP_MULH   = 6'b011001;
    localparam logic [5:0] OP_MULHSU = 6'b011010;
    localparam logic [5:0] OP_MULHU  = 6'b011011;
    localparam logic [5:0] OP_DIV    = 6'b011100;
    localparam logic [5:0] OP_DIVU   = 6'b011101;
    localparam logic [5:0] OP_REM    = 6'b011110;
    localparam logic [5:0] OP_REMU   = 6'b011111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Issue one op at a falling edge and wait (bounded) for done; no checking here.
    task automatic issue(
        input  logic [5:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] res,
        output logic        z,
        output int          lat,
        output bit          busy_ok,
        output bit          pulse_ok,
        output bit          tmo
    );
        bus.start      = 1'b1;
        bus.ALUControl = op;
        bus.operand1   = a;
        bus.operand2   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.operand1 = 32'h1234_5678;
        bus.operand2 = 32'h0000_0003;
        bus.ALUControl = OP_REMU;
        lat     = 0;
        busy_ok = 1'b1;
        tmo     = 1'b0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus.done !== 1'b1) tmo = 1'b1;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        res = bus.resultMulDiv;
        z   = bus.zero;
        @(negedge clk);
        pulse_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        checks++;
        if (bus.resultMulDiv !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h want 00000000", bus.resultMulDiv);
        end
        checks++;
        if (bus.zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_zero: got %b want 1", bus.zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [5:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] as  [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          bok, pok, tmo;
        bit          lat_ok;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], res, z, lat, bok, pok, tmo);
            checks++;
            if (tmo || res !== ex[i]) begin
                failures++;
                $display("FAIL mul_result[%0d]: got %h want %h tmo=%0b", i, res, ex[i], tmo);
            end
            checks++;
            if (z !== 1'b0) begin
                failures++;
                $display("FAIL mul_zero[%0d]: got %b want 0", i, z);
            end
`ifdef MULDIV_EARLY_OUT_EN
            lat_ok = (lat >= FAST) && (lat <= LAT);
`else
            lat_ok = (lat == LAT);
`endif
            checks++;
            if (!lat_ok) begin
                failures++;
                $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if (!bok || !pok) begin
                failures++;
                $display("FAIL mul_handshake[%0d]: busy_ok=%0b pulse_ok=%0b want 1 1", i, bok, pok);
            end
        end
    endtask

    task automatic test_div();
        logic [5:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] ex  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC,
                                 32'h1, 32'hFFFF_FFF2, 32'h2};
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          bok, pok, tmo;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], res, z, lat, bok, pok, tmo);
            checks++;
            if (tmo || res !== ex[i]) begin
                failures++;
                $display("FAIL div_result[%0d]: got %h want %h tmo=%0b", i, res, ex[i], tmo);
            end
            checks++;
            if (lat != LAT || !bok || !pok) begin
                failures++;
                $display("FAIL div_timing[%0d]: lat=%0d busy_ok=%0b pulse_ok=%0b want %0d 1 1",
                         i, lat, bok, pok, LAT);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [5:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic        ez  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          bok, pok, tmo;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], res, z, lat, bok, pok, tmo);
            checks++;
            if (tmo || res !== ex[i] || z !== ez[i]) begin
                failures++;
                $display("FAIL fast_result[%0d]: got %h/%b want %h/%b", i, res, z, ex[i], ez[i]);
            end
            checks++;
            if (lat != FAST || !pok) begin
                failures++;
                $display("FAIL fast_latency[%0d]: got %0d pulse_ok=%0b want %0d 1", i, lat, pok, FAST);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        logic        z1, z2;
        int          l1, l2;
        bit          b1, b2, p1, p2, t1, t2;
        issue(OP_DIVU, 32'd100, 32'd7, r1, z1, l1, b1, p1, t1);
        issue(OP_REMU, 32'd8, 32'd2, r2, z2, l2, b2, p2, t2);
        checks++;
        if (t1 || r1 !== 32'd14 || z1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got %h/%b want 0000000e/0", r1, z1);
        end
        checks++;
        if (t2 || r2 !== 32'd0 || z2 !== 1'b1 || l2 != LAT) begin
            failures++;
            $display("FAIL b2b_second: got %h/%b lat=%0d want 00000000/1 lat=%0d", r2, z2, l2, LAT);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          bok, pok, tmo;
        bit          busy_bad;
        bit          done_seen;
        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, res, z, lat, bok, pok, tmo);
        checks++;
        if (tmo || res !== 32'h4000_0000) begin
            failures++;
            $display("FAIL flush_setup: got %h want 40000000", res);
        end
        bus.start      = 1'b1;
        bus.ALUControl = OP_MUL;
        bus.operand1   = 32'd3;
        bus.operand2   = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy_bad  = 1'b0;
        done_seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (bus.done !== 1'b0) done_seen = 1'b1;
            if (k == 4) begin
                bus.start      = 1'b1;
                bus.ALUControl = OP_DIVU;
                bus.operand1   = 32'd9;
                bus.operand2   = 32'd0;
            end
            if (k == 5) bus.start = 1'b0;
        end
        checks++;
        if (busy_bad || done_seen) begin
            failures++;
            $display("FAIL flush_inflight: busy_bad=%0b done_seen=%0b want 0 0", busy_bad, done_seen);
        end
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL flush_abort: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.resultMulDiv !== 32'h4000_0000 || bus.zero !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold: got %h/%b want 40000000/0", bus.resultMulDiv, bus.zero);
        end
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            failures++;
            $display("FAIL flush_no_done: got activity after flush want none");
        end
        bus.start      = 1'b1;
        bus.flush      = 1'b1;
        bus.ALUControl = OP_MUL;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_wins: busy=%b want 0", bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_hazard();
        int lat;
        bus.start      = 1'b1;
        bus.ALUControl = OP_DIVU;
        bus.operand1   = 32'd100;
        bus.operand2   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 4) begin
                bus.start      = 1'b1;
                bus.ALUControl = OP_REMU;
                bus.operand1   = 32'hFFFF_FFFF;
                bus.operand2   = 32'd16;
            end
            if (lat == 5) bus.start = 1'b0;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.resultMulDiv !== 32'd14 || lat != LAT) begin
            failures++;
            $display("FAIL hazard_start_busy: got %h lat=%0d want 0000000e lat=%0d",
                     bus.resultMulDiv, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          bok, pok, tmo;
        bit          act;
        bit          lat_ok;
        bus.start      = 1'b1;
        bus.ALUControl = OP_DIVU;
        bus.operand1   = 32'hFFFF_FFF9;
        bus.operand2   = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ctrl: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.resultMulDiv !== 32'h0 || bus.zero !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_result: got %h/%b want 00000000/1", bus.resultMulDiv, bus.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.ALUControl = 6'b000010;
        bus.operand1   = 32'd5;
        bus.operand2   = 32'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        act = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) act = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (act) begin
            failures++;
            $display("FAIL non_muldiv_ignored: saw busy/done want none");
        end
        issue(OP_MUL, 32'd0, 32'd9, res, z, lat, bok, pok, tmo);
        checks++;
        if (tmo || res !== 32'h0 || z !== 1'b1) begin
            failures++;
            $display("FAIL mul_zero_result: got %h/%b want 00000000/1", res, z);
        end
`ifdef MULDIV_EARLY_OUT_EN
        lat_ok = (lat >= FAST) && (lat <= LAT);
`else
        lat_ok = (lat == LAT);
`endif
        checks++;
        if (!lat_ok || !pok) begin
            failures++;
            $display("FAIL mul_zero_latency: got %0d pulse_ok=%0b want %0d 1", lat, pok, LAT);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.ALUControl = 6'b0;
        bus.operand1   = '0;
        bus.operand2   = '0;
        bus.flush      = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_hazard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
